// File: rtl/tensor_matrix_loader.sv
// -----------------------------------------------------------------------------
// tensor_matrix_loader
//
// Purpose
//   Front end that turns a byte stream of matrix elements into tensor-core
//   load-immediate instructions on the CPU's current_instruction bus. One load
//   word is issued per accepted byte, for register-file addresses 0..31. Matrix
//   0 comes first (addresses 0..15), then matrix 1 (addresses 16..31), both in
//   row-major order. After the 32nd element the loader can issue the bulk
//   compute instruction. The bus then returns to NOP.
//
// Parameters
//   LOAD_OPCODE      opcode placed in [7:0] of every load-immediate word
//   COMPUTE_OPCODE   opcode of the bulk compute instruction
//   NOP_INSTRUCTION  word driven whenever nothing is issued
//   AUTO_COMPUTE     1: issue compute after element 31; 0: finish directly
//
// Ports
//   clock_in           rising-edge clock
//   reset_n_in         asynchronous active-low reset
//   start_in           begin a 32-element sequence (sampled only in IDLE)
//   abort_in           synchronous cancel while in LOAD or COMPUTE
//   byte_valid_in      byte_in holds an element
//   byte_in[7:0]       matrix element
//   byte_ready_out     loader accepts an element this cycle
//   instruction_out    registered instruction word for the CPU
//   busy_out           a sequence is in progress (state != IDLE)
//   done_out           one-cycle completion pulse (state == DONE)
//   element_count_out  elements accepted in the current sequence, 0..32
//   state_dbg_out      raw FSM state for observation
//
// Handshake
//   An element transfers at a rising edge when byte_valid_in and
//   byte_ready_out are both high at that edge. The producer holds byte_in
//   stable while valid is high and ready is low. Ready does not depend on
//   valid. Ready is high throughout LOAD, so the loader accepts one element
//   per cycle with no bubbles. The only exception is that abort_in forces
//   ready low in the same cycle, so the loader never accepts a byte while it
//   is aborting.
// -----------------------------------------------------------------------------
module tensor_matrix_loader #(
  parameter logic [7:0]  LOAD_OPCODE     = 8'h06,
  parameter logic [7:0]  COMPUTE_OPCODE  = 8'h05,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000,
  parameter int          AUTO_COMPUTE    = 1
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic        byte_valid_in,
  input  logic [7:0]  byte_in,
  output logic        byte_ready_out,
  output logic [31:0] instruction_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [5:0]  element_count_out,
  output logic [1:0]  state_dbg_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [5:0]  LAST_ADDR    = 6'd31;
  localparam logic [31:0] COMPUTE_WORD = {24'h00_0000, COMPUTE_OPCODE};
  localparam bit          DO_COMPUTE   = (AUTO_COMPUTE != 0);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [5:0]  r_count;
  logic [5:0]  w_count_nxt;
  logic        w_ready;
  logic        w_handshake;
  logic [31:0] w_load_word;

  // Abort gates ready so a byte offered in the abort cycle is never consumed.
  assign w_ready     = (r_state == S_LOAD) && !abort_in;
  assign w_handshake = w_ready && byte_valid_in;

  // The current count is the destination address of the byte being accepted.
  // Bits [15:8] and [31:29] are fixed at zero.
  assign w_load_word = {3'b000, r_count[4:0], byte_in, 8'h00, LOAD_OPCODE};

  // ---------------------------------------------------------------------------
  // Next-state, next-instruction and next-count logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = NOP_INSTRUCTION;
    w_count_nxt = r_count;

    unique case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_state_nxt = S_LOAD;
          w_count_nxt = 6'd0;
        end
      end

      S_LOAD: begin
        if (abort_in) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = 6'd0;
        end else if (w_handshake) begin
          w_instr_nxt = w_load_word;
          w_count_nxt = r_count + 6'd1;
          // The 32nd element ends the load phase. Ready falls in the next
          // cycle, so the count can never pass 32.
          if (r_count == LAST_ADDR) begin
            w_state_nxt = DO_COMPUTE ? S_COMPUTE : S_DONE;
          end
        end
      end

      S_COMPUTE: begin
        if (abort_in) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = 6'd0;
        end else begin
          // The compute word is registered as DONE is entered, so it shares
          // its single bus cycle with the done pulse.
          w_instr_nxt = COMPUTE_WORD;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // The count stays at 32 until the next start clears it.
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 6'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, instruction and count registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
      r_instr <= NOP_INSTRUCTION;
      r_count <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: status is decoded from the state register only
  // ---------------------------------------------------------------------------
  assign byte_ready_out    = w_ready;
  assign instruction_out   = r_instr;
  assign busy_out          = (r_state != S_IDLE);
  assign done_out          = (r_state == S_DONE);
  assign element_count_out = r_count;
  assign state_dbg_out     = r_state;

endmodule
